// File: rtl/multiplier_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multiplier_pkg
//  Description : Shared constants and types for the shift-add multiplier that
//                rebuilds a dividend as prod = qu * b + rem.
//                QW    - quotient (multiplicand-select) width
//                BW    - divisor / remainder width
//                PW    - product width (QW + BW)
//                CNT_W - iteration counter width
//  Revision    : 1.0 - initial release
// ============================================================================
package multiplier_pkg;

    localparam int QW    = 8;
    localparam int BW    = 4;
    localparam int PW    = QW + BW;

    // Iteration counter width for a given quotient width; never below 1 bit.
    function automatic int cnt_w(input int qw);
        return (qw > 1) ? $clog2(qw) : 1;
    endfunction

    localparam int CNT_W = cnt_w(QW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : multiplier
//  Description : Iterative shift-add multiplier, one quotient bit per clock.
//                Computes prod = qu * b + rem with a start/ready handshake.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous, active-low reset
//                start      - request, honoured in IDLE or DONE only
//                qu, b, rem - operands, captured on an accepted start
//                busy       - high while iterating
//                ready_out  - high in DONE, prod valid
//                prod       - result, held until the next accepted start
//  Revision    : 1.0 - initial release
// ============================================================================
module multiplier
    import multiplier_pkg::*;
#(
    parameter int QW = multiplier_pkg::QW,
    parameter int BW = multiplier_pkg::BW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [QW-1:0]      qu,
    input  logic [BW-1:0]      b,
    input  logic [BW-1:0]      rem,
    output logic               busy,
    output logic               ready_out,
    output logic [QW+BW-1:0]   prod
);

    localparam int PW_L = QW + BW;
    localparam int CW   = cnt_w(QW);

    state_e            state_q;
    logic [QW-1:0]     q_sh_q;
    logic [PW_L-1:0]   b_sh_q;
    logic [PW_L-1:0]   acc_q;
    logic [CW-1:0]     count_q;
    logic [PW_L-1:0]   acc_d;

    // One partial product per cycle. The accumulator is seeded with rem, so
    // the final sum is qu*b + rem; the width always covers the maximum.
    assign acc_d = acc_q + (q_sh_q[0] ? b_sh_q : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            q_sh_q    <= '0;
            b_sh_q    <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            busy      <= 1'b0;
            ready_out <= 1'b0;
            prod      <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        q_sh_q    <= qu;
                        b_sh_q    <= {{(PW_L-BW){1'b0}}, b};
                        acc_q     <= {{(PW_L-BW){1'b0}}, rem};
                        count_q   <= '0;
                        ready_out <= 1'b0;
                        busy      <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    q_sh_q  <= {1'b0, q_sh_q[QW-1:1]};
                    b_sh_q  <= {b_sh_q[PW_L-2:0], 1'b0};
                    count_q <= count_q + CW'(1);
                    // Last iteration: publish the freshly updated sum directly
                    // so the result appears on the same edge busy falls.
                    if (count_q == CW'(QW-1)) begin
                        prod      <= acc_d;
                        ready_out <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiplier
//  Description : Self-checking bench for the shift-add multiplier. Expected
//                products are queued when a request is driven and compared
//                when ready_out rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier;

    localparam int TQW = 8;
    localparam int TBW = 4;
    localparam int TPW = TQW + TBW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [TQW-1:0]  qu = '0;
    logic [TBW-1:0]  b = '0;
    logic [TBW-1:0]  rem = '0;
    logic            busy;
    logic            ready_out;
    logic [TPW-1:0]  prod;

    int              n_checks = 0;
    int              n_fail = 0;
    logic [TPW-1:0]  sb_q[$];

    multiplier #(.QW(TQW), .BW(TBW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .qu        (qu),
        .b         (b),
        .rem       (rem),
        .busy      (busy),
        .ready_out (ready_out),
        .prod      (prod)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one request, optionally keeping start high during RUN while
    // scrambling qu, then wait for the result and check timing and value.
    task automatic run_op(input logic [TQW-1:0] q_in, input logic [TBW-1:0] b_in,
                          input logic [TBW-1:0] r_in, input bit hold, input string tag);
        int lat    = 0;
        int busy_n = 0;
        bit seen   = 0;
        logic [TPW-1:0] exp;
        @(negedge clk);
        qu    = q_in;
        b     = b_in;
        rem   = r_in;
        start = 1'b1;
        sb_q.push_back(TPW'(q_in) * TPW'(b_in) + TPW'(r_in));
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        check({tag, "_rdy_low_on_accept"}, 32'(ready_out), 32'd0);
        check({tag, "_busy_on_accept"}, 32'(busy), 32'd1);
        if (busy) busy_n++;
        for (int c = 1; c <= TQW + 4 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (hold) begin
                if (c < TQW - 1) qu = TQW'($urandom);
                else start = 1'b0;
            end
            if (ready_out) begin
                seen = 1;
                lat  = c;
            end else if (busy) begin
                busy_n++;
            end
        end
        if (!seen) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end else begin
            check({tag, "_latency"}, 32'(lat), 32'(TQW));
            check({tag, "_busy_cycles"}, 32'(busy_n), 32'(TQW));
            check({tag, "_busy_at_ready"}, 32'(busy), 32'd0);
            exp = sb_q.pop_front();
            check({tag, "_prod"}, 32'(prod), 32'(exp));
        end
    endtask

    initial begin
        logic [TQW-1:0] a;
        logic [TBW-1:0] bb;

        // Reset held: outputs stay cleared regardless of start.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = ~start;
            qu    = 8'd17;
            b     = 4'd5;
            rem   = 4'd3;
            @(posedge clk);
            #1;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_ready", 32'(ready_out), 32'd0);
            check("rst_prod", 32'(prod), 32'd0);
        end
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;

        run_op(8'd17, 4'd5, 4'd3, 1'b0, "basic");
        run_op(8'd255, 4'd15, 4'd15, 1'b0, "max");
        check("max_const", 32'(prod), 32'd3840);
        run_op(8'd200, 4'd0, 4'd7, 1'b0, "b_zero");
        check("b_zero_const", 32'(prod), 32'd7);
        run_op(8'd0, 4'd9, 4'd12, 1'b0, "q_zero");
        run_op(8'd17, 4'd5, 4'd3, 1'b1, "hold_start");
        check("hold_start_const", 32'(prod), 32'd88);

        // DONE holds its result with no further requests.
        repeat (3) @(posedge clk);
        #1;
        check("done_hold_ready", 32'(ready_out), 32'd1);
        check("done_hold_prod", 32'(prod), 32'd88);

        run_op(8'd28, 4'd7, 4'd4, 1'b0, "restart");
        check("restart_const", 32'(prod), 32'd200);

        // Abort mid-RUN: async clear between edges.
        @(negedge clk);
        qu = 8'd255; b = 4'd15; rem = 4'd15; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(ready_out), 32'd0);
        check("abort_prod", 32'(prod), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_idle_ready", 32'(ready_out), 32'd0);
        run_op(8'd3, 4'd3, 4'd1, 1'b0, "after_abort");
        check("after_abort_const", 32'(prod), 32'd10);

        // Round trip through an ideal 8-by-4 divider.
        for (int v = 0; v < 1000; v++) begin
            a  = TQW'($urandom_range(0, 255));
            bb = TBW'($urandom_range(1, 15));
            run_op(a / TQW'(bb), bb, TBW'(a % TQW'(bb)), 1'b0, "rt");
            check("rt_dividend", 32'(prod), 32'(a));
        end

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/multiplier.md
# multiplier

Sequential shift-add multiplier that reconstructs a dividend from the divider's outputs: `prod = qu * b + rem`. It sits downstream of the 8-bit-by-4-bit divider and closes the divide/multiply loop, both for self-check and for datapaths that rescale a quotient. Operation is iterative, one multiplier bit per clock, with a start/ready handshake.

## Interface
- `QW`, default 8: quotient (multiplicand-select) width.
- `BW`, default 4: divisor and remainder width.
- `PW`, default `QW+BW` (derived): product width.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; clears all state immediately when low.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `qu`  in  QW  quotient operand; captured on an accepted `start`.
- `b`  in  BW  divisor operand; captured on an accepted `start`.
- `rem`  in  BW  remainder operand; captured on an accepted `start`.
- `busy`  out  1  high while in RUN.
- `ready_out`  out  1  high in DONE; `prod` is valid.
- `prod`  out  PW  result, held until the next accepted `start`.

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: `busy=0`, `ready_out=0`, `prod=0`, `count=0`, and all internal registers 0.
- IDLE or DONE with `start=1` → RUN on the same edge:
  - latch `q_sh=qu` and `b_sh={(PW-BW)'0, b}`;
  - set `acc={(PW-BW)'0, rem}` and `count=0`;
  - clear `ready_out`.
- Each RUN cycle:
  - if `q_sh[0]`, then `acc += b_sh`;
  - `q_sh >>= 1`, `b_sh <<= 1`, `count++`.
- On the edge where `count==QW-1`, the final iteration is performed. On that same edge:
  - `prod` loads the updated `acc`;
  - `ready_out=1`;
  - state → DONE.
- DONE holds `prod` and `ready_out` until an accepted `start`. No acknowledge is required.
- `start` during RUN is ignored; operands are not re-sampled.
- Width rule: there is no overflow. The maximum result is `(2^QW-1)(2^BW-1)+(2^BW-1) = (2^BW-1)·2^QW`, which is less than `2^PW`. All arithmetic is unsigned, and the adder is PW bits wide.
- `rem` is not required to be less than `b`; any value is accepted and added verbatim.
- `b=0` or `qu=0` gives `prod=rem` after the full QW cycles. There is no early exit.
- Reset asserted mid-RUN aborts the operation. All outputs return to their reset values asynchronously, and the FSM sits in IDLE after release.

## Timing
- Latency: `start` accepted at edge 0 → `ready_out` and `prod` valid after edge QW (8 cycles for the default).
- `busy` is high from after edge 0 through edge QW-1, and is low in the same cycle `ready_out` rises.
- Throughput: one result per QW+1 cycles if `start` is reasserted in DONE. A restart in DONE drops `ready_out` on the accepting edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - `QW`, `BW`, `PW` constants;
  - the FSM state enum (IDLE, RUN, DONE);
  - the `count` width `$clog2(QW)`.
- No sub-module; the single PW-bit add and the shifters stay inline in one module.

## Test plan
- Reset: hold `rst=0` while toggling `start` → `busy=0`, `ready_out=0`, `prod=0` throughout.
- Basic case: `qu=17`, `b=5`, `rem=3`, pulse `start` → `ready_out` rises exactly 8 cycles later with `prod=88`, and `busy` is high for 8 cycles.
- Maximum operands: `qu=255`, `b=15`, `rem=15` → `prod=3840`. Also `qu=200`, `b=0`, `rem=7` → `prod=7` after the full 8 cycles.
- Handshake:
  - `start` held high through RUN with changing `qu` → result uses the first captured `qu`;
  - `start` in DONE with `qu=28`, `b=7`, `rem=4` → `ready_out` drops, then rises 8 cycles later with `prod=200`.
- Reset mid-operation: drive `rst` low at iteration 4 → outputs clear immediately. A fresh `start` with `qu=3`, `b=3`, `rem=1` then gives `prod=10`.
- Round trip: random `a`, `b≠0` through the divider then this block → `prod==a` across 1000 vectors. The check is restricted to the divider's correct range.
